// File: rtl/int_to_fp_pkg.sv
// Shared definitions for the 16-bit integer to 13-bit float converter:
// field widths, FSM encoding, saturation value and the magnitude helper.
package int_to_fp_pkg;

  localparam int INT_W = 16;
  localparam int FP_W  = 13;
  localparam int EXP_W = 4;
  localparam int MAN_W = 8;

  // The exponent counts down from INT_W, so it needs one bit more than the field
  localparam logic [EXP_W:0]   EXP_START = 5'd16;
  localparam logic [FP_W-1:0]  FP_SAT    = 13'h1FFF;
  localparam logic [FP_W-1:0]  FP_ZERO   = 13'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of a two's-complement value; -32768 maps to 16'h8000 unsigned
  function automatic logic [INT_W-1:0] abs_mag(input logic [INT_W-1:0] v);
    logic [INT_W-1:0] m;
    if (v[INT_W-1]) begin
      m = ~v + 16'd1;
    end else begin
      m = v;
    end
    return m;
  endfunction

endpackage

// File: rtl/int_to_fp.sv
// Sequential integer-to-float converter: normalizes the magnitude one bit per
// cycle and emits {sign, exp[3:0], mantissa[7:0]} with a done_tick pulse.
module int_to_fp
  import int_to_fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [INT_W-1:0]  din,
  output logic              ready,
  output logic              done_tick,
  output logic [FP_W-1:0]   dout,
  output logic              ovf
);

  state_t            state_r;
  logic              sign_r;
  logic [INT_W-1:0]  mag_r;
  logic [EXP_W:0]    exp_r;

  // Control FSM and datapath; all outputs are registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      sign_r    <= 1'b0;
      mag_r     <= '0;
      exp_r     <= '0;
      ready     <= 1'b1;
      done_tick <= 1'b0;
      dout      <= FP_ZERO;
      ovf       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_tick <= 1'b0;
          if (start) begin
            sign_r  <= din[INT_W-1];
            mag_r   <= abs_mag(din);
            exp_r   <= EXP_START;
            ready   <= 1'b0;
            state_r <= ST_NORM;
          end else begin
            ready   <= 1'b1;
          end
        end

        ST_NORM: begin
          if (mag_r == '0) begin
            dout      <= FP_ZERO;
            ovf       <= 1'b0;
            done_tick <= 1'b1;
            state_r   <= ST_DONE;
          end else if (mag_r[INT_W-1]) begin
            // An unshifted MSB means |din| = 2^15, which the 4-bit exponent cannot hold
            if (exp_r == EXP_START) begin
              dout <= FP_SAT;
              ovf  <= 1'b1;
            end else begin
              dout <= {sign_r, exp_r[EXP_W-1:0], mag_r[INT_W-1 -: MAN_W]};
              ovf  <= 1'b0;
            end
            done_tick <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            mag_r <= {mag_r[INT_W-2:0], 1'b0};
            exp_r <= exp_r - 5'd1;
          end
        end

        ST_DONE: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state_r   <= ST_IDLE;
        end

        default: begin
          done_tick <= 1'b0;
          ready     <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp.sv
// Self-checking bench for int_to_fp: directed corner values, start/reset
// interaction and randomized conversions against an arithmetic reference.
module tb_int_to_fp;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] din;
  logic        ready;
  logic        done_tick;
  logic [12:0] dout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_to_fp dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .ready     (ready),
    .done_tick (done_tick),
    .dout      (dout),
    .ovf       (ovf)
  );

  // Reference: value = 0.m * 2^e with e the bit length of |din|
  function automatic void ref_model(input logic [15:0] d, output logic [12:0] r,
                                    output logic rovf, output int lat);
    int v, m, e, man;
    v = int'($signed(d));
    if (v == 0) begin
      r = 13'h0000; rovf = 1'b0; lat = 2;
      return;
    end
    m = (v < 0) ? -v : v;
    e = 0;
    while ((1 << e) <= m) e++;
    lat = (16 - e) + 2;
    if (e > 15) begin
      r = 13'h1FFF; rovf = 1'b1;
    end else begin
      man = (m * 256) >> e;
      r = {(v < 0) ? 1'b1 : 1'b0, 4'(e), 8'(man)};
      rovf = 1'b0;
    end
  endfunction

  // Drive one conversion from a negedge; returns at the negedge showing done_tick
  task automatic run_conv(input logic [15:0] d, output logic [12:0] got, output logic gov,
                          output int lat, output logic overlap, output int waited);
    overlap = 1'b0;
    waited  = 0;
    got     = 13'h0000;
    gov     = 1'b0;
    while (!ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      lat = -1;
      return;
    end
    start = 1'b1;
    din   = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    din   = 16'($urandom);
    lat   = 1;
    forever begin
      if (ready && done_tick) overlap = 1'b1;
      if (done_tick || lat >= 40) break;
      @(negedge clk);
      lat++;
    end
    if (!done_tick) lat = -1;
    got = dout;
    gov = ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; din = 16'h0000;
    repeat (2) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (done_tick !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_tick); end
    checks++; if (dout !== 13'h0000) begin errors++; $display("FAIL reset_dout got %h exp 0000", dout); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] vin [7]  = '{16'h0300, 16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h0040};
    logic [12:0] vout [7] = '{13'h0AC0, 13'h0180, 13'h1180, 13'h0000, 13'h0FFF, 13'h1FFF, 13'h0780};
    logic        vovf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          vlat [7] = '{8, 17, 17, 2, 3, 2, 11};
    logic [12:0] got; logic gov, ovl; int lat, w;
    for (int i = 0; i < 7; i++) begin
      run_conv(vin[i], got, gov, lat, ovl, w);
      checks++; if (got !== vout[i]) begin errors++; $display("FAIL dir_dout din=%h got %h exp %h", vin[i], got, vout[i]); end
      checks++; if (gov !== vovf[i]) begin errors++; $display("FAIL dir_ovf din=%h got %b exp %b", vin[i], gov, vovf[i]); end
      checks++; if (lat != vlat[i]) begin errors++; $display("FAIL dir_lat din=%h got %0d exp %0d", vin[i], lat, vlat[i]); end
      checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL dir_overlap din=%h got %b exp 0", vin[i], ovl); end
    end
  endtask

  task automatic test_hold();
    logic [12:0] got; logic gov, ovl; int lat, w;
    run_conv(16'h8000, got, gov, lat, ovl, w);
    repeat (4) @(negedge clk);
    checks++; if (dout !== 13'h1FFF) begin errors++; $display("FAIL hold_sat_dout got %h exp 1fff", dout); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL hold_ovf got %b exp 1", ovf); end
    checks++; if (ready !== 1'b1 || done_tick !== 1'b0) begin errors++; $display("FAIL hold_idle got rdy=%b dt=%b exp 1/0", ready, done_tick); end
  endtask

  task automatic test_ignore_start();
    int k;
    @(negedge clk);
    start = 1'b1; din = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; din = 16'h7FFF;
    k = 1;
    while (!done_tick && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 5) begin start = 1'b1; din = 16'h7FFF; end
      else start = 1'b0;
    end
    start = 1'b0;
    checks++; if (k != 17) begin errors++; $display("FAIL ignore_lat got %0d exp 17", k); end
    checks++; if (dout !== 13'h0180) begin errors++; $display("FAIL ignore_dout got %h exp 0180", dout); end
    // A queued start would produce a second result shortly after
    k = 0;
    repeat (6) begin @(negedge clk); if (done_tick) k++; end
    checks++; if (k != 0) begin errors++; $display("FAIL ignore_extra_done got %0d exp 0", k); end
  endtask

  task automatic test_reset_abort();
    int k;
    @(negedge clk);
    start = 1'b1; din = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", ready); end
    checks++; if (dout !== 13'h0000) begin errors++; $display("FAIL abort_dout got %h exp 0000", dout); end
    k = 0;
    repeat (20) begin @(negedge clk); if (done_tick) k++; end
    checks++; if (k != 0) begin errors++; $display("FAIL abort_done got %0d exp 0", k); end
    // Reset wins over a simultaneous start
    reset = 1'b1; start = 1'b1; din = 16'h7FFF;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL prio_ready got %b exp 1", ready); end
    k = 0;
    repeat (6) begin @(negedge clk); if (done_tick) k++; end
    checks++; if (k != 0) begin errors++; $display("FAIL prio_done got %0d exp 0", k); end
  endtask

  task automatic test_back_to_back();
    logic [12:0] got; logic gov, ovl; int lat, w;
    run_conv(16'h0300, got, gov, lat, ovl, w);
    run_conv(16'hFF00, got, gov, lat, ovl, w);
    checks++; if (w != 1) begin errors++; $display("FAIL b2b_gap got %0d exp 1", w); end
    checks++; if (got !== 13'h1980) begin errors++; $display("FAIL b2b_dout got %h exp 1980", got); end
    checks++; if (lat != 9) begin errors++; $display("FAIL b2b_lat got %0d exp 9", lat); end
  endtask

  task automatic test_random();
    logic [12:0] got, exp_d; logic gov, exp_o, ovl; int lat, exp_l, w;
    logic [15:0] d;
    for (int i = 0; i < 10000; i++) begin
      d = 16'($urandom);
      if (i % 8 == 0) begin
        d = d >> $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) d = -d;
      end
      if (i % 1000 == 0) d = 16'h8000;
      ref_model(d, exp_d, exp_o, exp_l);
      run_conv(d, got, gov, lat, ovl, w);
      checks++; if (got !== exp_d) begin errors++; $display("FAIL rnd_dout din=%h got %h exp %h", d, got, exp_d); end
      checks++; if (gov !== exp_o) begin errors++; $display("FAIL rnd_ovf din=%h got %b exp %b", d, gov, exp_o); end
      checks++; if (lat != exp_l) begin errors++; $display("FAIL rnd_lat din=%h got %0d exp %0d", d, lat, exp_l); end
      checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL rnd_overlap din=%h got %b exp 0", d, ovl); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; din = 16'h0000;
    @(negedge clk);
    test_reset();
    test_directed();
    test_hold();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
